// File: rtl/prll_bs_rr_rtr.sv
// Round-robin arbiter that pops one packet at a time from N driver FIFOs and routes it by ID field.
// Optional RR_STATS_EN adds saturating tx_cnt / drp_cnt counters.
module prll_bs_rr_rtr #(
  parameter int unsigned        drvrs     = 4,
  parameter int unsigned        bits      = 32,
  parameter int unsigned        id_bits   = 8,
  parameter logic [id_bits-1:0] broadcast = id_bits'(8'hFF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [drvrs-1:0]        pndng,
  input  logic [drvrs*bits-1:0]   d_pop,
  output logic [drvrs-1:0]        pop,
  input  logic [drvrs-1:0]        full,
  output logic [drvrs-1:0]        push,
  output logic [drvrs*bits-1:0]   d_push,
  output logic                    busy
`ifdef RR_STATS_EN
  ,
  output logic [15:0]             tx_cnt,
  output logic [15:0]             drp_cnt
`endif
);

  localparam int unsigned GW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

  state_t            state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     winner;
  logic              found;
  logic [bits-1:0]   data;
  logic [bits-1:0]   sent;
  logic [drvrs-1:0]  mask;
  logic [drvrs-1:0]  mask_c;
  logic [id_bits-1:0] dest;
  logic              fire;
  logic              drop;
  int                idx;
  logic [bits-1:0]   d_arr [drvrs];

  for (genvar g = 0; g < int'(drvrs); g++) begin : g_slot
    assign d_arr[g] = d_pop[g*bits +: bits];
  end

  // First pending driver after the previous grant, wrapping modulo drvrs
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= int'(drvrs); k++) begin
      idx = (int'(last_grant) + k) % int'(drvrs);
      if (!found && pndng[GW'(idx)]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  // Destination mask from the latched packet's ID field
  always_comb begin
    dest = data[bits-1 -: id_bits];
    if (dest == broadcast)
      mask_c = ~(drvrs'(1) << grant);
    else if (32'(dest) < drvrs)
      mask_c = drvrs'(1) << dest;
    else
      mask_c = '0;
  end

  // Push is decided against this cycle's full; a reset cycle never pushes
  assign fire   = (state == SEND) && (mask != '0) && ((mask & full) == '0) && !reset;
  assign drop   = (state == SEND) && (mask == '0);
  assign push   = fire ? mask : '0;
  assign d_push = {drvrs{fire ? data : sent}};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pop        <= '0;
      last_grant <= GW'(drvrs - 1);
      grant      <= '0;
      data       <= '0;
      sent       <= '0;
      mask       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= winner;
            data  <= d_arr[winner];
            pop   <= drvrs'(1) << winner;
            state <= POP;
          end
        end
        POP: begin
          pop        <= '0;
          last_grant <= grant;
          mask       <= mask_c;
          state      <= SEND;
        end
        SEND: begin
          if (drop) begin
            state <= IDLE;
          end else if (fire) begin
            sent  <= data;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RR_STATS_EN
  // Saturating traffic statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt  <= '0;
      drp_cnt <= '0;
    end else begin
      if (fire && tx_cnt != 16'hFFFF)
        tx_cnt <= tx_cnt + 16'd1;
      if (drop && drp_cnt != 16'hFFFF)
        drp_cnt <= drp_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prll_bs_rr_rtr.sv
// Bench for prll_bs_rr_rtr: directed literal scenarios plus randomized traffic against a
// transaction-level model (packet in flight, age, target set).
module tb_prll_bs_rr_rtr;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     pndng;
  logic [N*W-1:0]   d_pop;
  logic [N-1:0]     pop;
  logic [N-1:0]     full;
  logic [N-1:0]     push;
  logic [N*W-1:0]   d_push;
  logic             busy;
`ifdef RR_STATS_EN
  logic [15:0]      tx_cnt;
  logic [15:0]      drp_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  prll_bs_rr_rtr #(.drvrs(N), .bits(W), .id_bits(8), .broadcast(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .d_pop  (d_pop),
    .pop    (pop),
    .full   (full),
    .push   (push),
    .d_push (d_push),
`ifdef RR_STATS_EN
    .tx_cnt (tx_cnt),
    .drp_cnt(drp_cnt),
`endif
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] slot(input logic [N*W-1:0] v, input int i);
    return W'(v >> (i * W));
  endfunction

  task automatic set_slot(input int i, input logic [W-1:0] v);
    d_pop = (d_pop & ~({{(N*W-W){1'b0}}, {W{1'b1}}} << (i * W))) | ((N*W)'(v) << (i * W));
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] targets(input logic [W-1:0] pkt, input int src);
    int id;
    id = int'(pkt[W-1 -: 8]);
    if (id == 255) return N'((1 << N) - 1) & ~N'(1 << src);
    if (id < N)    return N'(1 << id);
    return '0;
  endfunction

  bit           m_ok = 1'b0;
  bit           m_busy;
  int           m_age;
  int           m_grant;
  int           m_last;
  logic [W-1:0] m_data;
  logic [W-1:0] m_sent;
  logic [N-1:0] m_mask;
  logic [15:0]  m_tx;
  logic [15:0]  m_drp;

  always @(posedge clk) begin
    if (reset) begin
      m_ok   <= 1'b1;
      m_busy <= 1'b0;
      m_age  <= 0;
      m_last <= N - 1;
      m_sent <= '0;
      m_tx   <= '0;
      m_drp  <= '0;
    end else if (m_ok) begin
      if (m_busy) begin
        if (m_age == 1) begin
          m_age <= 2;
        end else if (m_mask == '0) begin
          m_busy <= 1'b0;
          if (m_drp != 16'hFFFF) m_drp <= m_drp + 16'd1;
        end else if ((m_mask & full) == '0) begin
          m_busy <= 1'b0;
          m_sent <= m_data;
          if (m_tx != 16'hFFFF) m_tx <= m_tx + 16'd1;
        end
      end else if (pndng != '0) begin
        m_busy  <= 1'b1;
        m_age   <= 1;
        m_grant <= rr_pick(pndng, m_last);
        m_last  <= rr_pick(pndng, m_last);
        m_data  <= slot(d_pop, rr_pick(pndng, m_last));
        m_mask  <= targets(slot(d_pop, rr_pick(pndng, m_last)), rr_pick(pndng, m_last));
      end
    end
  end

  // Compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (m_ok) begin
      logic         f;
      logic [N-1:0] ep;
      f  = m_busy && (m_age == 2) && (m_mask != '0) && ((m_mask & full) == '0) && !reset;
      ep = (m_busy && m_age == 1) ? N'(1 << m_grant) : '0;
      chk("m_pop",    (N*W)'(pop),  (N*W)'(ep));
      chk("m_push",   (N*W)'(push), (N*W)'(f ? m_mask : '0));
      chk("m_d_push", d_push,       {N{f ? m_data : m_sent}});
      chk("m_busy",   (N*W)'(busy), (N*W)'(m_busy));
`ifdef RR_STATS_EN
      chk("m_tx_cnt",  (N*W)'(tx_cnt),  (N*W)'(m_tx));
      chk("m_drp_cnt", (N*W)'(drp_cnt), (N*W)'(m_drp));
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_idle: busy still 1 after 60 cycles, required 0");
    end
    @(posedge clk); #1;
  endtask

  // Launch one packet from drv (DUT idle, called at posedge+1); checks pop and first SEND cycle
  task automatic send_one(input string nm, input int drv, input logic [W-1:0] pkt,
                          input logic [N-1:0] exp_push);
    set_slot(drv, pkt);
    pndng = N'(1 << drv);
    @(posedge clk); #1;
    pndng = '0;
    @(negedge clk);
    chk({nm, "_pop"}, (N*W)'(pop), (N*W)'(N'(1 << drv)));
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_push"}, (N*W)'(push), (N*W)'(exp_push));
  endtask

  function automatic logic [W-1:0] rnd_pkt();
    int r;
    logic [7:0] id;
    r = $urandom_range(0, 9);
    if (r < 6)       id = 8'(r % N);
    else if (r < 8)  id = 8'hFF;
    else if (r == 8) id = 8'h07;
    else             id = 8'($urandom);
    return {id, 24'($urandom)};
  endfunction

  initial begin
    int pop_at [$];
    logic [N-1:0] pop_seq [$];

    reset = 1'b1; pndng = '0; full = '0; d_pop = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_pop",    (N*W)'(pop),  '0);
    chk("rst_push",   (N*W)'(push), '0);
    chk("rst_busy",   (N*W)'(busy), '0);
    chk("rst_d_push", d_push,       '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Round-robin with all drivers pending
    for (int i = 0; i < N; i++) set_slot(i, {8'((i + 1) % N), 24'h00_1000 + 24'(i)});
    pndng = '1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (pop != '0) begin pop_at.push_back(c); pop_seq.push_back(pop); end
    end
    @(posedge clk); #1;
    pndng = '0;
    chk("rr_count", (N*W)'(pop_seq.size()), (N*W)'(5));
    if (pop_seq.size() == 5) begin
      chk("rr_g0", (N*W)'(pop_seq[0]), (N*W)'(4'b0001));
      chk("rr_g1", (N*W)'(pop_seq[1]), (N*W)'(4'b0010));
      chk("rr_g2", (N*W)'(pop_seq[2]), (N*W)'(4'b0100));
      chk("rr_g3", (N*W)'(pop_seq[3]), (N*W)'(4'b1000));
      chk("rr_g4", (N*W)'(pop_seq[4]), (N*W)'(4'b0001));
      chk("rr_spacing", (N*W)'(pop_at[4] - pop_at[0]), (N*W)'(12));
    end
    wait_idle();

    // Unicast drv1 -> drv2
    send_one("uni", 1, 32'h0200_00AB, 4'b0100);
    chk("uni_d_push_slot2", (N*W)'(slot(d_push, 2)), (N*W)'(32'h0200_00AB));
    wait_idle();

    // Broadcast from drv2
    send_one("bcast", 2, 32'hFF00_1234, 4'b1011);
    chk("bcast_d_push", d_push, {N{32'hFF00_1234}});
    @(posedge clk); @(negedge clk);
    chk("bcast_single", (N*W)'(push), '0);
    wait_idle();

    // Drop on out-of-range ID
    send_one("drop", 0, 32'h0700_0001, 4'b0000);
    @(posedge clk); @(negedge clk);
    chk("drop_idle", (N*W)'(busy), '0);
    chk("drop_hold", (N*W)'(slot(d_push, 0)), (N*W)'(32'hFF00_1234));
    wait_idle();

    // Backpressure on drv3
    full = 4'b1000;
    send_one("bp", 0, 32'h0300_0055, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_stall_push", (N*W)'(push), '0);
      chk("bp_stall_busy", (N*W)'(busy), (N*W)'(1));
    end
    @(posedge clk); #1;
    full = '0;
    @(negedge clk);
    chk("bp_release", (N*W)'(push), (N*W)'(4'b1000));
    wait_idle();

    // Reset while stalled in SEND
    full = 4'b0010;
    send_one("rs", 2, 32'h0100_0077, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rs_no_push", (N*W)'(push), '0);
    @(posedge clk); #1;
    reset = 1'b0; full = '0;
    @(negedge clk);
    chk("rs_pop",  (N*W)'(pop),  '0);
    chk("rs_push", (N*W)'(push), '0);
    chk("rs_busy", (N*W)'(busy), '0);
    pndng = '1;
    @(posedge clk); #1;
    pndng = '0;
    @(negedge clk);
    chk("rs_first_grant", (N*W)'(pop), (N*W)'(4'b0001));
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pndng = N'($urandom);
      for (int i = 0; i < N; i++) set_slot(i, rnd_pkt());
      full  = N'($urandom) & N'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; pndng = '0; full = '0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
